// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge: FSM states,
// access sizes and the byte-enable patterns the bridge accepts.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: byte-enable legality and size decode, store
// data replication across lanes, and load lane extraction with extension.
module dmem_lane_unit (
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic        signed_i,
  output logic        legal_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o
);
  import dmem_pkg::*;

  size_e       size_s;
  logic [7:0]  lane8_s;
  logic [15:0] lane16_s;

  // Decode be into legality, access size and the selected load lane
  always_comb begin
    legal_o  = 1'b0;
    size_s   = SZ_WORD;
    lane8_s  = 8'h00;
    lane16_s = 16'h0000;
    case (be_i)
      BE_B0: begin legal_o = 1'b1; size_s = SZ_BYTE; lane8_s = rdata_i[7:0];   end
      BE_B1: begin legal_o = 1'b1; size_s = SZ_BYTE; lane8_s = rdata_i[15:8];  end
      BE_B2: begin legal_o = 1'b1; size_s = SZ_BYTE; lane8_s = rdata_i[23:16]; end
      BE_B3: begin legal_o = 1'b1; size_s = SZ_BYTE; lane8_s = rdata_i[31:24]; end
      BE_H0: begin legal_o = 1'b1; size_s = SZ_HALF; lane16_s = rdata_i[15:0];  end
      BE_H1: begin legal_o = 1'b1; size_s = SZ_HALF; lane16_s = rdata_i[31:16]; end
      BE_W:  begin legal_o = 1'b1; size_s = SZ_WORD; end
      default: begin legal_o = 1'b0; size_s = SZ_WORD; end
    endcase
  end

  // Replicate store data and right-align/extend load data by size
  always_comb begin
    wdata_rep_o = wdata_i;
    rdata_ext_o = rdata_i;
    case (size_s)
      SZ_BYTE: begin
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_ext_o = {{24{signed_i & lane8_s[7]}}, lane8_s};
      end
      SZ_HALF: begin
        wdata_rep_o = {2{wdata_i[15:0]}};
        rdata_ext_o = {{16{signed_i & lane16_s[15]}}, lane16_s};
      end
      SZ_WORD: begin
        wdata_rep_o = wdata_i;
        rdata_ext_o = rdata_i;
      end
      default: begin
        wdata_rep_o = wdata_i;
        rdata_ext_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Core data-side bridge: turns single-cycle load/store requests into a
// req/ack bus transaction, stalling the core and flagging bad be or timeout.
module dmem_bridge #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [3:0]  byteEnable,
  input  logic        load_signed,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  import dmem_pkg::*;

  state_e           state_q;
  logic             we_q;
  logic             sgn_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             fault_q;

  logic [3:0]       lane_be_s;
  logic             lane_legal_s;
  logic [31:0]      lane_wdata_s;
  logic [31:0]      lane_rdata_s;
  logic             in_req_s;

  // In IDLE the lane unit judges the incoming access; afterwards the latched one
  assign lane_be_s = (state_q == ST_IDLE) ? byteEnable : be_q;

  dmem_lane_unit u_lane (
    .be_i        (lane_be_s),
    .wdata_i     (WriteData),
    .rdata_i     (bus_rdata),
    .signed_i    (sgn_q),
    .legal_o     (lane_legal_s),
    .wdata_rep_o (lane_wdata_s),
    .rdata_ext_o (lane_rdata_s)
  );

  // Transaction FSM with wait counter and latched access fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      cnt_q   <= '0;
      rdata_q <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rdata_q <= 32'h0000_0000;
          fault_q <= 1'b0;
          if (core_req) begin
            we_q    <= MemWrite;
            sgn_q   <= load_signed;
            addr_q  <= ALUResult & 32'hFFFF_FFFC;
            be_q    <= byteEnable;
            wdata_q <= lane_wdata_s;
            cnt_q   <= '0;
            if (lane_legal_s) begin
              state_q <= ST_REQ;
            end else begin
              state_q <= ST_RESP;
              fault_q <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            state_q <= ST_RESP;
            rdata_q <= we_q ? 32'h0000_0000 : lane_rdata_s;
            fault_q <= 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q <= ST_RESP;
            rdata_q <= 32'h0000_0000;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          rdata_q <= 32'h0000_0000;
          fault_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          rdata_q <= 32'h0000_0000;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_req_s  = (state_q == ST_REQ);
  assign bus_req   = in_req_s;
  assign bus_we    = in_req_s & we_q;
  assign bus_be    = in_req_s ? be_q : 4'b0000;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign ReadData  = rdata_q;
  assign fault     = fault_q;
  // Reset must release the core at once, even while core_req is still held
  assign stall     = ~reset & (((state_q == ST_IDLE) & core_req) | in_req_s);

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: hand-computed expectations for loads,
// stores, illegal byte enables, timeout and mid-transaction reset.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [3:0]  byteEnable;
  logic        load_signed;
  logic [31:0] ReadData;
  logic        stall;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  int          o_stalls;
  int          o_reqs;
  logic [31:0] o_rd;
  logic        o_fault;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_be;
  logic        o_we;

  dmem_bridge #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .byteEnable (byteEnable),
    .load_signed(load_signed),
    .ReadData   (ReadData),
    .stall      (stall),
    .fault      (fault),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Run one core access; ack on REQ cycle number ack_after+1 (never if < 0)
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic sgn, input int ack_after,
                           input logic [31:0] rdata);
    bit done = 1'b0;
    o_stalls = 0; o_reqs = 0; o_rd = 32'hx; o_fault = 1'bx;
    o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0; o_we = 1'b0;
    core_req = 1'b1; MemWrite = we; ALUResult = addr; WriteData = wdata;
    byteEnable = be; load_signed = sgn; bus_rdata = rdata; bus_ack = 1'b0;
    #1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (stall) begin
        o_stalls++;
        if (bus_req) begin
          o_reqs++;
          o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be; o_we = bus_we;
          bus_ack = (ack_after >= 0) && (o_reqs > ack_after);
        end
        step();
      end else begin
        o_rd = ReadData; o_fault = fault;
        core_req = 1'b0; bus_ack = 1'b0;
        done = 1'b1;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $error("FAIL access_bound: observed no RESP expected RESP within 60 cycles");
    end
    step();
    chk("idle_fault_clear", {31'd0, fault}, 32'd0);
    chk("idle_rdata_clear", ReadData, 32'h0);
    chk("idle_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; core_req = 1'b0; MemWrite = 1'b0; ALUResult = 32'h0;
    WriteData = 32'h0; byteEnable = 4'h0; load_signed = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    step(); step();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    reset = 1'b0;
    step();

    // Word load, ack on first REQ cycle
    do_access(1'b0, 32'h0000_0100, 32'h0, 4'b1111, 1'b0, 0, 32'hDEAD_BEEF);
    chk("wl_stalls", o_stalls, 32'd2);
    chk("wl_reqs", o_reqs, 32'd1);
    chk("wl_addr", o_addr, 32'h0000_0100);
    chk("wl_we", {31'd0, o_we}, 32'd0);
    chk("wl_rdata", o_rd, 32'hDEAD_BEEF);
    chk("wl_fault", {31'd0, o_fault}, 32'd0);

    // Byte store at 0x203, ack after 3 waits
    do_access(1'b1, 32'h0000_0203, 32'h0000_00A5, 4'b1000, 1'b0, 3, 32'h1234_5678);
    chk("bs_stalls", o_stalls, 32'd5);
    chk("bs_reqs", o_reqs, 32'd4);
    chk("bs_addr", o_addr, 32'h0000_0200);
    chk("bs_wdata", o_wdata, 32'hA5A5_A5A5);
    chk("bs_be", {28'd0, o_be}, 32'h8);
    chk("bs_we", {31'd0, o_we}, 32'd1);
    chk("bs_rdata", o_rd, 32'h0);
    chk("bs_fault", {31'd0, o_fault}, 32'd0);

    // Half store, low lanes
    do_access(1'b1, 32'h0000_0010, 32'h1234_BEEF, 4'b0011, 1'b0, 1, 32'h0);
    chk("hs_wdata", o_wdata, 32'hBEEF_BEEF);
    chk("hs_be", {28'd0, o_be}, 32'h3);
    chk("hs_stalls", o_stalls, 32'd3);

    // Upper-half loads, signed and unsigned
    do_access(1'b0, 32'h0000_0302, 32'h0, 4'b1100, 1'b1, 0, 32'h8001_1234);
    chk("hl_signed", o_rd, 32'hFFFF_8001);
    chk("hl_s_be", {28'd0, o_be}, 32'hC);
    do_access(1'b0, 32'h0000_0302, 32'h0, 4'b1100, 1'b0, 0, 32'h8001_1234);
    chk("hl_unsigned", o_rd, 32'h0000_8001);

    // Byte loads from lane 1, signed and unsigned, and lane 2 positive
    do_access(1'b0, 32'h0000_0041, 32'h0, 4'b0010, 1'b1, 0, 32'h1122_F733);
    chk("bl_signed", o_rd, 32'hFFFF_FFF7);
    do_access(1'b0, 32'h0000_0041, 32'h0, 4'b0010, 1'b0, 0, 32'h1122_F733);
    chk("bl_unsigned", o_rd, 32'h0000_00F7);
    do_access(1'b0, 32'h0000_0042, 32'h0, 4'b0100, 1'b1, 0, 32'h1172_F733);
    chk("bl_lane2", o_rd, 32'h0000_0072);

    // Illegal byte enables: no bus activity, one stall, fault
    do_access(1'b0, 32'h0000_0500, 32'h0, 4'b0101, 1'b0, 0, 32'hFFFF_FFFF);
    chk("ill_reqs", o_reqs, 32'd0);
    chk("ill_stalls", o_stalls, 32'd1);
    chk("ill_fault", {31'd0, o_fault}, 32'd1);
    chk("ill_rdata", o_rd, 32'h0);
    do_access(1'b1, 32'h0000_0500, 32'h0, 4'b0000, 1'b0, 0, 32'h0);
    chk("ill0_reqs", o_reqs, 32'd0);
    chk("ill0_fault", {31'd0, o_fault}, 32'd1);

    // Timeout with no ack
    do_access(1'b0, 32'h0000_0600, 32'h0, 4'b1111, 1'b0, -1, 32'hCAFE_F00D);
    chk("to_reqs", o_reqs, 32'd16);
    chk("to_stalls", o_stalls, 32'd17);
    chk("to_fault", {31'd0, o_fault}, 32'd1);
    chk("to_rdata", o_rd, 32'h0);

    // Ack on the timeout cycle completes normally
    do_access(1'b0, 32'h0000_0600, 32'h0, 4'b1111, 1'b0, 15, 32'hCAFE_F00D);
    chk("tack_reqs", o_reqs, 32'd16);
    chk("tack_fault", {31'd0, o_fault}, 32'd0);
    chk("tack_rdata", o_rd, 32'hCAFE_F00D);

    // Reset in the middle of REQ
    core_req = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0000_0700;
    byteEnable = 4'b1111; load_signed = 1'b0; bus_ack = 1'b0;
    step();
    chk("mr_in_req", {31'd0, bus_req}, 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("mr_bus_req", {31'd0, bus_req}, 32'd0);
    chk("mr_stall", {31'd0, stall}, 32'd0);
    chk("mr_bus_addr", bus_addr, 32'h0);
    step();
    reset = 1'b0; core_req = 1'b0;
    step();
    do_access(1'b0, 32'h0000_0804, 32'h0, 4'b1111, 1'b0, 2, 32'h0BAD_CAFE);
    chk("pr_stalls", o_stalls, 32'd4);
    chk("pr_addr", o_addr, 32'h0000_0804);
    chk("pr_rdata", o_rd, 32'h0BAD_CAFE);
    chk("pr_fault", {31'd0, o_fault}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-side stage directly downstream of the core's load/store outputs (MemWrite, ALUResult as address, WriteData, byteEnable); it returns ReadData to the core.
- Turns each single-cycle core access into a request/acknowledge transaction on a variable-latency data bus.
- Stalls the core until the transaction completes, replicates store data across byte lanes, and extracts and extends load data.
- Detects illegal byte-enable patterns and bus timeouts, and reports them as faults.

Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for bus_ack before the access is aborted with a fault.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core presents a load or store this cycle; held stable while stall=1
- MemWrite  in  1  1 = store, 0 = load
- ALUResult  in  32  byte address
- WriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- byteEnable  in  4  lane mask, already shifted by address
- load_signed  in  1  1 = sign-extend a byte/half load, 0 = zero-extend
- ReadData  out  32  extracted, extended load data; valid while state=RESP
- stall  out  1  freeze core pipeline
- fault  out  1  one-cycle pulse, aligned with RESP, when the access was aborted
- bus_req  out  1  bus request
- bus_we  out  1  bus write enable
- bus_addr  out  32  word address, bits [1:0]=00
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  bus byte strobes
- bus_ack  in  1  bus completion
- bus_rdata  in  32  raw bus word

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (asynchronous) forces IDLE. Reset values: all registered fields 0, counter 0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, ReadData=0, fault=0, stall=0.
- Reset asserted mid-transaction abandons it immediately. bus_req drops in the same cycle reset asserts.
- stall = (state==IDLE & core_req) | (state==REQ). stall=0 in RESP, so the core advances on the RESP clock edge.
- Transitions out of IDLE, when core_req=1, latch we, addr, be, wdata and signed:
  - IDLE to REQ when be is legal.
  - IDLE to RESP with err set when be is illegal. No bus activity occurs.
  - Legal be values: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Every other value is illegal, including 0000.
- REQ:
  - bus_req=1 and bus signals driven from the latched registers, stable for the whole REQ state.
  - bus_ack=1 goes to RESP; on a load, capture bus_rdata.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack, go to RESP with err set.
  - An ack arriving on the timeout cycle takes priority: the access completes normally.
- RESP: lasts exactly one cycle, then goes to IDLE.
  - fault=err.
  - ReadData is the extracted load value. It is 0 for stores and for faulted accesses.
  - A core_req seen in RESP is not launched. It is evaluated in the following IDLE cycle; it is the next instruction's request.
- Minimum latency: 2 stall cycles (IDLE, then REQ with ack) before RESP. Each extra bus wait cycle adds 1.
- Store lane replication:
  - byte: wdata[7:0] x4
  - half: wdata[15:0] x2
  - word: as-is
  - bus_be = latched be.
- Load extraction: select the lane set by the one-hot/pair be from the captured word, right-align it, then sign- or zero-extend per signed. Word loads pass through unchanged.
- bus_addr = {addr[31:2], 2'b00}. The bridge does no further alignment check; be legality is the only fault source besides timeout.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum
  - localparams for the legal be patterns
  - a size enum (BYTE, HALF, WORD) decoded from be
- Natural sub-module: dmem_lane_unit. It is combinational: store replication, load extraction and extension, be legality and size decode.
- The FSM, counter and registers stay in dmem_bridge.

Test Plan:
- Word load at 0x100, be=1111, ack on the first REQ cycle, rdata=0xDEADBEEF -> bus_addr=0x100, stall high for 2 cycles, ReadData=0xDEADBEEF in RESP, fault=0.
- Byte store at 0x203, be=1000, WriteData=0x000000A5, ack after 3 waits -> bus_wdata=0xA5A5A5A5, bus_be=1000, bus_we=1, stall high for 5 cycles.
- Signed half load, be=1100, rdata=0x8001xxxx -> ReadData=0xFFFF8001. The same access with load_signed=0 -> ReadData=0x00008001.
- be=0101 with core_req -> no bus_req ever, RESP next cycle, fault=1, ReadData=0.
- No ack, TIMEOUT=16 -> bus_req held exactly 16 cycles, then fault pulse. Repeat with ack arriving on the 16th cycle -> normal completion, fault=0.
- Reset asserted in the middle of REQ -> bus_req=0 and stall=0 immediately. After reset, a new load completes normally.
